// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the conditional-branch sequencer.
// State encoding, default branch opcode, IR field positions and C2 codes.
package branch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_DONE
    } state_t;

    localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

    // IR field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int C2_HI  = 20;
    localparam int C2_LO  = 19;
    localparam int C_HI   = 18;
    localparam int C_LO   = 0;

    // Condition codes carried in C2
    localparam logic [1:0] C2_ZR = 2'b00;
    localparam logic [1:0] C2_NZ = 2'b01;
    localparam logic [1:0] C2_PL = 2'b10;
    localparam logic [1:0] C2_MI = 2'b11;

endpackage

// File: rtl/branch_sequencer_if.sv
// Handshake/strobe bundle between the control requester and the branch sequencer.
// master: requester side (drives start/ir/con_in); slave: the sequencer.
interface branch_sequencer_if;

    logic        start;
    logic [31:0] ir;
    logic        con_in;

    logic [1:0]  cond_sel;
    logic        gra;
    logic        r_out;
    logic        con_en;
    logic        pc_out;
    logic        y_in;
    logic        c_out;
    logic        alu_add;
    logic        z_in;
    logic        z_lo_out;
    logic        pc_in;
    logic [31:0] c_sext;
    logic        busy;
    logic        done;
    logic        taken;
    logic        reject;

    modport master (
        output start, ir, con_in,
        input  cond_sel, gra, r_out, con_en, pc_out, y_in, c_out, alu_add,
               z_in, z_lo_out, pc_in, c_sext, busy, done, taken, reject
    );

    modport slave (
        input  start, ir, con_in,
        output cond_sel, gra, r_out, con_en, pc_out, y_in, c_out, alu_add,
               z_in, z_lo_out, pc_in, c_sext, busy, done, taken, reject
    );

endinterface

// File: rtl/branch_sequencer.sv
// Conditional-branch control sequencer: IDLE -> T0..T3 -> DONE.
// T0 evaluates the condition on Ra, T1/T2 compute PC + C, T3 writes PC only
// when the branch is taken. Optional outcome counters behind BRANCH_STATS_EN.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic              clock,
    input  logic              clear,
    branch_sequencer_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt
`endif
);

    state_t      r_state;
    state_t      w_next;
    // Only the instruction fields the sequencer consumes are held.
    logic [1:0]  r_c2;
    logic [18:0] r_c;
    logic        r_taken_q;
    logic        r_reject;
    logic        w_is_br;
    logic        w_launch;

    assign w_is_br  = (bus.ir[OPC_HI:OPC_LO] == BR_OPCODE);
    assign w_launch = (r_state == S_IDLE) && bus.start && w_is_br;

    // State register; clear wins over any pending start.
    always_ff @(posedge clock) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Latch the instruction fields on launch; later ir changes are ignored.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_c2 <= '0;
            r_c  <= '0;
        end else if (w_launch) begin
            r_c2 <= bus.ir[C2_HI:C2_LO];
            r_c  <= bus.ir[C_HI:C_LO];
        end
    end

    // Capture the condition result at the edge that ends T0.
    always_ff @(posedge clock) begin
        if (clear)                 r_taken_q <= 1'b0;
        else if (r_state == S_T0)  r_taken_q <= bus.con_in;
    end

    // One-cycle reject for a start carrying a non-branch opcode.
    always_ff @(posedge clock) begin
        if (clear) r_reject <= 1'b0;
        else       r_reject <= (r_state == S_IDLE) && bus.start && !w_is_br;
    end

    // Next state and per-state strobe decode; every strobe defaults low.
    always_comb begin
        w_next       = r_state;
        bus.gra      = 1'b0;
        bus.r_out    = 1'b0;
        bus.con_en   = 1'b0;
        bus.pc_out   = 1'b0;
        bus.y_in     = 1'b0;
        bus.c_out    = 1'b0;
        bus.alu_add  = 1'b0;
        bus.z_in     = 1'b0;
        bus.z_lo_out = 1'b0;
        bus.pc_in    = 1'b0;
        bus.done     = 1'b0;
        bus.taken    = 1'b0;
        bus.busy     = 1'b1;
        bus.cond_sel = r_c2;
        case (r_state)
            S_IDLE: begin
                bus.busy     = 1'b0;
                bus.cond_sel = 2'b00;
                if (w_launch) w_next = S_T0;
            end
            S_T0: begin
                bus.gra    = 1'b1;
                bus.r_out  = 1'b1;
                bus.con_en = 1'b1;
                w_next     = S_T1;
            end
            S_T1: begin
                bus.pc_out = 1'b1;
                bus.y_in   = 1'b1;
                w_next     = S_T2;
            end
            S_T2: begin
                bus.c_out   = 1'b1;
                bus.alu_add = 1'b1;
                bus.z_in    = 1'b1;
                w_next      = S_T3;
            end
            S_T3: begin
                bus.z_lo_out = 1'b1;
                bus.pc_in    = r_taken_q;
                w_next       = S_DONE;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                bus.taken = r_taken_q;
                w_next    = S_IDLE;
            end
            default: begin
                bus.busy     = 1'b0;
                bus.cond_sel = 2'b00;
                w_next       = S_IDLE;
            end
        endcase
    end

    assign bus.c_sext = {{13{r_c[18]}}, r_c};
    assign bus.reject = r_reject;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_not_taken_cnt;

    // Saturating outcome counters, bumped once per completed branch.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_taken_cnt     <= '0;
            r_not_taken_cnt <= '0;
        end else if (r_state == S_DONE) begin
            if (r_taken_q) begin
                if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 1'b1;
            end else begin
                if (r_not_taken_cnt != '1) r_not_taken_cnt <= r_not_taken_cnt + 1'b1;
            end
        end
    end

    assign taken_cnt     = r_taken_cnt;
    assign not_taken_cnt = r_not_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: stimulus pushes expected outcomes,
// a negedge monitor checks per-cycle strobes and pops on done/reject.
module tb_branch_sequencer;
    import branch_pkg::*;

    typedef struct {
        bit          is_rej;
        logic        taken;
        logic [1:0]  cs;
        logic [31:0] cx;
    } exp_t;

    logic clock;
    logic clear;
    int   checks;
    int   errors;
    exp_t sb[$];
    bit   mon_en;

    branch_sequencer_if bif();

`ifdef BRANCH_STATS_EN
    localparam int CW = 2;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] not_taken_cnt;
    branch_sequencer #(.CNT_W(CW)) dut (
        .clock(clock), .clear(clear), .bus(bif.slave),
        .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
    );
`else
    branch_sequencer dut (.clock(clock), .clear(clear), .bus(bif.slave));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // expected {gra,r_out,con_en,pc_out,y_in,c_out,alu_add,z_in,z_lo_out} per busy cycle
    function automatic logic [8:0] exp_tab(input int idx);
        case (idx)
            0:       return 9'b111_00_000_0;
            1:       return 9'b000_11_000_0;
            2:       return 9'b000_00_111_0;
            3:       return 9'b000_00_000_1;
            default: return 9'b000_00_000_0;
        endcase
    endfunction

    // monitor
    int   idx = -1;
    bit   prev_busy = 1'b0;
    always @(negedge clock) begin
        logic [8:0] w;
        exp_t       it;
        if (mon_en) begin
            w = {bif.gra, bif.r_out, bif.con_en, bif.pc_out, bif.y_in,
                 bif.c_out, bif.alu_add, bif.z_in, bif.z_lo_out};
            if (bif.busy === 1'b1) begin
                idx = prev_busy ? idx + 1 : 0;
                chk("strobes", {23'd0, w}, {23'd0, exp_tab(idx)});
                chk("bus_excl", ($countones({bif.r_out, bif.pc_out, bif.c_out, bif.z_lo_out}) > 1), 0);
                if (idx == 0 && sb.size() > 0) begin
                    chk("t0_cond_sel", {30'd0, bif.cond_sel}, {30'd0, sb[0].cs});
                    chk("t0_c_sext", bif.c_sext, sb[0].cx);
                end
                if (idx == 3) chk("t3_pc_in", {31'd0, bif.pc_in}, (sb.size() > 0) ? {31'd0, sb[0].taken} : 32'd0);
                else          chk("pc_in_off", {31'd0, bif.pc_in}, 0);
            end else begin
                idx = -1;
                chk("idle_outputs", {18'd0, w, bif.pc_in, bif.done, bif.taken, bif.cond_sel}, 0);
            end
            if (bif.done === 1'b1 || bif.reject === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, bif.done, bif.reject}, 0);
                end else begin
                    it = sb.pop_front();
                    chk("pulse_kind", {31'd0, bif.reject}, {31'd0, it.is_rej});
                    if (!it.is_rej) begin
                        chk("done_taken", {31'd0, bif.taken}, {31'd0, it.taken});
                        chk("done_cond_sel", {30'd0, bif.cond_sel}, {30'd0, it.cs});
                        chk("done_c_sext", bif.c_sext, it.cx);
                        chk("latency", idx, 4);
                    end else begin
                        chk("reject_busy", {31'd0, bif.busy}, 0);
                    end
                end
            end
            prev_busy = (bif.busy === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Launch one branch; start stays high while busy and a valid start is shown in DONE.
    task automatic branch(input logic [31:0] irv, input logic con,
                          input logic [1:0] ecs, input logic [31:0] ecx, input logic etk);
        exp_t e;
        e.is_rej = 1'b0; e.taken = etk; e.cs = ecs; e.cx = ecx;
        sb.push_back(e);
        bif.ir = irv; bif.start = 1'b1;
        tick();                                   // T0
        bif.ir = ~irv; bif.con_in = con;
        tick();                                   // T1
        bif.con_in = ~con;
        tick();                                   // T2
        tick();                                   // T3
        tick();                                   // DONE
        bif.ir = irv;
        tick();                                   // IDLE
        bif.start = 1'b0;
        tick();
        chk("no_restart", {31'd0, bif.busy}, 0);
    endtask

    initial begin
        exp_t e;
        checks = 0; errors = 0; mon_en = 1'b0;
        clear = 1'b1; bif.start = 1'b0; bif.ir = '0; bif.con_in = 1'b0;
        repeat (3) tick();
        clear = 1'b0;
        mon_en = 1'b1;
        chk("rst_busy", {31'd0, bif.busy}, 0);
        chk("rst_flags", {28'd0, bif.done, bif.taken, bif.reject, bif.pc_in}, 0);
        chk("rst_cond_sel", {30'd0, bif.cond_sel}, 0);
        chk("rst_c_sext", bif.c_sext, 0);

        branch(32'h9280_0023, 1'b1, C2_ZR, 32'h0000_0023, 1'b1);
        branch(32'h9288_0023, 1'b0, C2_NZ, 32'h0000_0023, 1'b0);
        branch(32'h9287_FFFF, 1'b1, C2_ZR, 32'hFFFF_FFFF, 1'b1);
        branch(32'h9294_0000, 1'b0, C2_PL, 32'hFFFC_0000, 1'b0);
        branch(32'h929F_FFFE, 1'b1, C2_MI, 32'hFFFF_FFFE, 1'b1);

        // non-branch opcode
        e.is_rej = 1'b1; e.taken = 1'b0; e.cs = 2'b00; e.cx = 32'd0;
        sb.push_back(e);
        bif.ir = 32'h1280_0023; bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        chk("rej_busy", {31'd0, bif.busy}, 0);
        repeat (2) tick();

        // clear in T2 aborts without pc_in/done
        bif.ir = 32'h9288_0023; bif.start = 1'b1;
        tick();                                   // T0
        bif.start = 1'b0; bif.con_in = 1'b1;
        tick();                                   // T1
        tick();                                   // T2
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", {31'd0, bif.busy}, 0);
        chk("clr_flags", {28'd0, bif.done, bif.taken, bif.reject, bif.pc_in}, 0);
        chk("clr_c_sext", bif.c_sext, 0);
        chk("clr_cond_sel", {30'd0, bif.cond_sel}, 0);
`ifdef BRANCH_STATS_EN
        chk("clr_taken_cnt", {30'd0, taken_cnt}, 0);
        chk("clr_not_taken_cnt", {30'd0, not_taken_cnt}, 0);
`endif
        repeat (4) tick();

        // clear beats start in the same cycle
        bif.ir = 32'h9280_0023; bif.start = 1'b1; clear = 1'b1;
        tick();
        bif.start = 1'b0; clear = 1'b0;
        chk("clr_prio_busy", {31'd0, bif.busy}, 0);
        chk("clr_prio_reject", {31'd0, bif.reject}, 0);
        repeat (2) tick();

`ifdef BRANCH_STATS_EN
        repeat (4) branch(32'h9280_0023, 1'b1, C2_ZR, 32'h0000_0023, 1'b1);
        chk("sat_taken_cnt", {30'd0, taken_cnt}, 3);
        chk("sat_not_taken_cnt", {30'd0, not_taken_cnt}, 0);
        branch(32'h9288_0023, 1'b0, C2_NZ, 32'h0000_0023, 1'b0);
        chk("nt_taken_cnt", {30'd0, taken_cnt}, 3);
        chk("nt_not_taken_cnt", {30'd0, not_taken_cnt}, 1);
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter BR_OPCODE, default 5'b10010, is the IR[31:27] value identifying a conditional branch.
REQ-002 Parameter CNT_W, default 16, is the statistics counter width.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to execute the instruction on ir; sampled only in IDLE.
REQ-006 ir  input  32  instruction word: opcode [31:27], Ra [26:23], C2 [20:19], C [18:0].
REQ-007 con_in  input  1  condition result returned by the CON flip-flop.
REQ-008 cond_sel  output  2  condition code to CON flip-flop (latched C2).
REQ-009 gra, r_out, con_en  output  1 each  select Ra, drive Ra onto bus, enable CON evaluation.
REQ-010 pc_out, y_in, c_out, alu_add, z_in, z_lo_out, pc_in  output  1 each  datapath strobes.
REQ-011 c_sext  output  32  sign-extended C field of the latched instruction.
REQ-012 busy, done, taken, reject  output  1 each  status; done, reject are single-cycle pulses.

Function
REQ-013 FSM states SHALL be IDLE, T0, T1, T2, T3, DONE; IDLE->T0->T1->T2->T3->DONE->IDLE unconditionally once started.
REQ-014 In IDLE with start=1 and ir[31:27]==BR_OPCODE, ir SHALL be latched into ir_q and the FSM SHALL enter T0.
REQ-015 In IDLE with start=1 and any other opcode, reject SHALL pulse high next cycle and the FSM SHALL stay IDLE.
REQ-016 start SHALL be ignored in every state except IDLE; ir changes after latch SHALL have no effect.
REQ-017 T0: gra=r_out=con_en=1; cond_sel=ir_q[20:19] from T0 through DONE, 2'b00 in IDLE.
REQ-018 con_in SHALL be sampled into taken_q at the rising edge ending T0; later changes of con_in SHALL be ignored.
REQ-019 T1: pc_out=y_in=1; T2: c_out=alu_add=z_in=1; T3: z_lo_out=1 and pc_in=taken_q.
REQ-020 DONE: done=1 and taken=taken_q for exactly one cycle; taken=0 in all other states.
REQ-021 busy SHALL be 1 in T0..DONE and 0 in IDLE; start-to-done latency SHALL be exactly 5 cycles.
REQ-022 Every strobe not listed for the current state SHALL be 0; no two bus drivers (r_out, pc_out, c_out, z_lo_out) SHALL be high together.
REQ-023 c_sext SHALL equal {{13{ir_q[18]}}, ir_q[18:0]}, stable from T0 through DONE.
REQ-024 A start presented in the DONE cycle SHALL be ignored; back-to-back branches need start in IDLE.

Reset
REQ-025 clear=1 at any edge, including mid-sequence, SHALL force IDLE, ir_q=0, taken_q=0; no pc_in pulse SHALL follow.
REQ-026 Reset values: all strobes, busy, done, taken, reject, cond_sel and c_sext SHALL be 0.
REQ-027 clear SHALL take priority over start in the same cycle.

Configuration
REQ-028 With BRANCH_STATS_EN defined, outputs taken_cnt and not_taken_cnt (CNT_W bits) SHALL increment at DONE per outcome, saturate at all-ones, and clear to 0 on clear.
REQ-029 Without BRANCH_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Package branch_pkg SHALL hold the state enum, BR_OPCODE default, IR field position constants and C2 code constants (ZR=00, NZ=01, PL=10, MI=11).
REQ-031 Implementation SHALL be a single module with no sub-module; sign extension and counters are inline.

Verification
REQ-032 ir=0x92800023, start=1, con_in=1 in T0 -> cond_sel=00, c_sext=0x00000023, pc_in=1 in T3, done=taken=1 five cycles after start.
REQ-033 ir=0x92880023, con_in=0 in T0 -> cond_sel=01, pc_in=0 in T3, done=1, taken=0.
REQ-034 ir with C=19'h7FFFF -> c_sext=0xFFFFFFFF; con_in toggled after T0 -> taken unchanged.
REQ-035 ir=0x12800023 with start=1 -> reject pulses once, busy stays 0, no strobes asserted.
REQ-036 clear asserted in T2 -> next cycle IDLE, all outputs 0, no pc_in or done pulse; with BRANCH_STATS_EN counters read 0.
REQ-037 BRANCH_STATS_EN, CNT_W=2, four taken branches -> taken_cnt saturates at 3, not_taken_cnt=0.
